// File: rtl/uninasoc_irq_arbiter.sv
// ============================================================================
// Module      : uninasoc_irq_arbiter
// Description : Edge-captured, masked, round-robin interrupt arbiter with a
//               claim/complete handshake (one source in service at a time).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uninasoc_irq_arbiter #(
    parameter int NUM_IRQ = 3,
    parameter int ID_W    = $clog2(NUM_IRQ + 1)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    output logic               irq_o,
    input  logic               claim_req_i,
    output logic               claim_valid_o,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               complete_i,
    input  logic [ID_W-1:0]    complete_id_i,
    output logic [NUM_IRQ-1:0] pending_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_IRQ-1:0] r_src_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [ID_W-1:0]    r_rr;
    logic [ID_W-1:0]    r_svc_id;
    logic               r_claim_valid;
    logic [ID_W-1:0]    r_claim_id;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_svc_mask;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_clr;
    logic               w_found;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_grant;
    logic               w_done;

    assign w_edge = irq_src_i & ~r_src_q;
    assign w_elig = r_pending & irq_en_i & ~w_svc_mask;

    always_comb begin
        w_svc_mask = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_svc_mask[k] = (r_state == S_SERVICE) && (r_svc_id == ID_W'(k + 1));
        end
    end

    // Round-robin scan: first eligible index at or above the pointer, wrapping.
    always_comb begin
        int v_idx;
        w_found   = 1'b0;
        w_win_idx = '0;
        v_idx     = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            v_idx = int'(r_rr) + i;
            if (v_idx >= NUM_IRQ) begin
                v_idx = v_idx - NUM_IRQ;
            end
            if (!w_found && w_elig[v_idx]) begin
                w_found   = 1'b1;
                w_win_idx = ID_W'(v_idx);
            end
        end
    end

    assign w_grant = (r_state == S_PENDING) && claim_req_i && w_found;
    assign w_done  = (r_state == S_SERVICE) && complete_i && (complete_id_i == r_svc_id);

    always_comb begin
        w_clr = '0;
        if (w_grant) begin
            w_clr[w_win_idx] = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (|w_elig) w_next_state = S_PENDING;
            S_PENDING: begin
                if (!w_found)         w_next_state = S_IDLE;
                else if (claim_req_i) w_next_state = S_SERVICE;
            end
            S_SERVICE: if (w_done) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Sampled through reset so sources already high at release give no edge.
    always_ff @(posedge clock_i) begin
        r_src_q <= irq_src_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_pending     <= '0;
            r_rr          <= '0;
            r_svc_id      <= '0;
            r_claim_valid <= 1'b0;
            r_claim_id    <= '0;
        end else begin
            r_pending     <= (r_pending & ~w_clr) | w_edge;
            r_claim_valid <= claim_req_i;
            if (claim_req_i) begin
                r_claim_id <= w_grant ? (w_win_idx + ID_W'(1)) : '0;
            end
            if (w_grant) begin
                r_svc_id <= w_win_idx + ID_W'(1);
            end
            if (w_done) begin
                r_rr <= (r_svc_id == ID_W'(NUM_IRQ)) ? '0 : r_svc_id;
            end
        end
    end

    assign irq_o         = (r_state == S_PENDING);
    assign claim_valid_o = r_claim_valid;
    assign claim_id_o    = r_claim_id;
    assign pending_o     = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_uninasoc_irq_arbiter.sv
// ============================================================================
// Module      : tb_uninasoc_irq_arbiter
// Description : Directed scenarios plus random traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uninasoc_irq_arbiter;

    localparam int N   = 3;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src;
    logic [N-1:0]   en;
    logic           irq;
    logic           claim;
    logic           cvalid;
    logic [IDW-1:0] cid;
    logic           cmpl;
    logic [IDW-1:0] cmpl_id;
    logic [N-1:0]   pend;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0=idle, 1=pending, 2=service
    int m_state, m_rr, m_svc, m_valid, m_id;
    int m_pend[N];
    int m_prev[N];

    uninasoc_irq_arbiter #(.NUM_IRQ(N), .ID_W(IDW)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .irq_src_i     (src),
        .irq_en_i      (en),
        .irq_o         (irq),
        .claim_req_i   (claim),
        .claim_valid_o (cvalid),
        .claim_id_o    (cid),
        .complete_i    (cmpl),
        .complete_id_i (cmpl_id),
        .pending_o     (pend)
    );

    always #5 clk = ~clk;

    task automatic model_next();
        int elig[$];
        int winner;
        int nstate;
        if (rst) begin
            m_state = 0; m_rr = 0; m_svc = 0; m_valid = 0; m_id = 0;
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 0;
                m_prev[k] = int'(src[k]);
            end
            return;
        end
        for (int j = 0; j < N; j++) begin
            int k;
            k = (m_rr + j) % N;
            if (m_pend[k] != 0 && en[k] && !(m_state == 2 && m_svc == k)) elig.push_back(k);
        end
        winner = (elig.size() > 0) ? elig[0] : -1;
        nstate = m_state;
        if (claim) begin
            m_valid = 1;
            m_id    = (m_state == 1 && winner >= 0) ? winner + 1 : 0;
        end else begin
            m_valid = 0;
        end
        if (m_state == 0) begin
            if (winner >= 0) nstate = 1;
        end else if (m_state == 1) begin
            if (winner < 0) nstate = 0;
            else if (claim) begin
                nstate = 2;
                m_svc  = winner;
                m_pend[winner] = 0;
            end
        end else begin
            if (cmpl && int'(cmpl_id) == m_svc + 1) begin
                nstate = 0;
                m_rr   = (m_svc + 1) % N;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (src[k] && m_prev[k] == 0) m_pend[k] = 1;
            m_prev[k] = int'(src[k]);
        end
        m_state = nstate;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        src = 3'b111; en = 3'b111; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_tests++; if (pend !== 3'b000) begin n_fail++; $display("FAIL reset_pend: got %b expected 000", pend); end
        n_tests++; if (cvalid !== 1'b0 || cid !== 2'd0) begin n_fail++; $display("FAIL reset_claim: got %b/%0d expected 0/0", cvalid, cid); end
        src = 3'b000;
        tick();
    endtask

    task automatic test_single();
        en = 3'b111; src = 3'b010;
        tick();
        src = 3'b000;
        n_tests++; if (pend !== 3'b010 || irq !== 1'b0) begin n_fail++; $display("FAIL single_capture: got pend=%b irq=%b expected 010/0", pend, irq); end
        tick();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq_latency: got %b expected 1", irq); end
        claim = 1'b1; tick(); claim = 1'b0;
        n_tests++; if (cvalid !== 1'b1 || cid !== 2'd2) begin n_fail++; $display("FAIL single_claim: got %b/%0d expected 1/2", cvalid, cid); end
        n_tests++; if (irq !== 1'b0 || pend !== 3'b000) begin n_fail++; $display("FAIL single_service: got irq=%b pend=%b expected 0/000", irq, pend); end
        tick();
        n_tests++; if (cvalid !== 1'b0 || cid !== 2'd2) begin n_fail++; $display("FAIL single_hold: got %b/%0d expected 0/2", cvalid, cid); end
        cmpl = 1'b1; cmpl_id = 2'd2; tick(); cmpl = 1'b0;
        tick();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", irq); end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 3'b111; src = 3'b101; tick(); src = 3'b000; tick();
        claim = 1'b1; tick(); claim = 1'b0;
        n_tests++; if (cid !== 2'd1) begin n_fail++; $display("FAIL rr_first: got %0d expected 1", cid); end
        src = 3'b001; tick(); src = 3'b000;
        cmpl = 1'b1; cmpl_id = 2'd1; tick(); cmpl = 1'b0;
        tick();
        n_tests++; if (irq !== 1'b1 || pend !== 3'b101) begin n_fail++; $display("FAIL rr_repend: got irq=%b pend=%b expected 1/101", irq, pend); end
        claim = 1'b1; tick(); claim = 1'b0;
        n_tests++; if (cid !== 2'd3) begin n_fail++; $display("FAIL rr_second: got %0d expected 3", cid); end
        cmpl = 1'b1; cmpl_id = 2'd3; tick(); cmpl = 1'b0;
        tick();
        claim = 1'b1; tick(); claim = 1'b0;
        n_tests++; if (cid !== 2'd1) begin n_fail++; $display("FAIL rr_third: got %0d expected 1", cid); end
        cmpl = 1'b1; cmpl_id = 2'd1; tick(); cmpl = 1'b0;
    endtask

    task automatic test_mask();
        do_reset();
        en = 3'b000; src = 3'b001; tick(); src = 3'b000; tick(); tick();
        n_tests++; if (pend !== 3'b001 || irq !== 1'b0) begin n_fail++; $display("FAIL mask_gate: got pend=%b irq=%b expected 001/0", pend, irq); end
        en = 3'b001; tick();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_enable: got %b expected 1", irq); end
        en = 3'b000; claim = 1'b1; tick(); claim = 1'b0;
        n_tests++; if (cvalid !== 1'b1 || cid !== 2'd0) begin n_fail++; $display("FAIL mask_drop_claim: got %b/%0d expected 1/0", cvalid, cid); end
        n_tests++; if (irq !== 1'b0 || pend !== 3'b001) begin n_fail++; $display("FAIL mask_drop_state: got irq=%b pend=%b expected 0/001", irq, pend); end
    endtask

    task automatic test_bad_complete();
        do_reset();
        en = 3'b111; src = 3'b010; tick(); src = 3'b000; tick();
        claim = 1'b1; tick(); claim = 1'b0;
        src = 3'b001; tick(); src = 3'b000;
        cmpl = 1'b1; cmpl_id = 2'd3; tick(); cmpl = 1'b0;
        tick();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL badcmpl_ignored: got irq=%b expected 0", irq); end
        claim = 1'b1; tick(); claim = 1'b0;
        n_tests++; if (cvalid !== 1'b1 || cid !== 2'd0) begin n_fail++; $display("FAIL badcmpl_claim: got %b/%0d expected 1/0", cvalid, cid); end
        cmpl = 1'b1; cmpl_id = 2'd2; tick(); cmpl = 1'b0;
        tick();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL badcmpl_release: got %b expected 1", irq); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 3'b001; src = 3'b001; tick(); src = 3'b000; tick();
        src = 3'b001; claim = 1'b1; tick(); claim = 1'b0; src = 3'b000;
        n_tests++; if (cid !== 2'd1 || pend !== 3'b001) begin n_fail++; $display("FAIL b2b_set_wins: got id=%0d pend=%b expected 1/001", cid, pend); end
    endtask

    task automatic test_reset_service();
        do_reset();
        en = 3'b111; src = 3'b010; tick(); src = 3'b000; tick();
        claim = 1'b1; tick(); claim = 1'b0;
        src = 3'b101; tick(); src = 3'b000;
        n_tests++; if (pend !== 3'b101) begin n_fail++; $display("FAIL rstsvc_setup: got %b expected 101", pend); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++; if (irq !== 1'b0 || cvalid !== 1'b0 || cid !== 2'd0 || pend !== 3'b000) begin
            n_fail++; $display("FAIL rstsvc_clear: got irq=%b v=%b id=%0d pend=%b expected all 0", irq, cvalid, cid, pend);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_pend;
        do_reset();
        en = 3'b111;
        for (int c = 0; c < 600; c++) begin
            src   = N'($urandom_range(0, 7));
            claim = ($urandom_range(0, 3) == 0);
            cmpl  = ($urandom_range(0, 3) == 0);
            cmpl_id = ($urandom_range(0, 2) != 0) ? IDW'(m_svc + 1) : IDW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) en = N'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            tick();
            for (int k = 0; k < N; k++) exp_pend[k] = (m_pend[k] != 0);
            n_tests++;
            if (irq !== (m_state == 1) || cvalid !== (m_valid != 0) ||
                cid !== IDW'(m_id) || pend !== exp_pend) begin
                n_fail++;
                $display("FAIL random_c%0d: got irq=%b v=%b id=%0d pend=%b expected irq=%0d v=%0d id=%0d pend=%b",
                         c, irq, cvalid, cid, pend, (m_state == 1), m_valid, m_id, exp_pend);
            end
        end
        rst = 1'b0; claim = 1'b0; cmpl = 1'b0; src = '0;
    endtask

    initial begin
        rst = 1'b1; src = '0; en = '0; claim = 1'b0; cmpl = 1'b0; cmpl_id = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_bad_complete();
        test_back_to_back();
        test_reset_service();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
